oam_dma_arbiter: RTL and testbench
==================================

OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have parameter DMA_LEN, default 160, bytes per DMA transfer.
REQ-002 SHALL have parameter DMA_REG_ADDR, default 16'hFF46, CPU-visible DMA start register address.
REQ-003 SHALL have parameter OAM_BASE_HI, default 8'hFE, destination high byte.
REQ-004 SHALL have port clk, input, 1, clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port cpu_addr, input, 16, CPU address.
REQ-007 SHALL have port cpu_wdata, input, 8, CPU write data.
REQ-008 SHALL have port cpu_re, input, 1, CPU read request.
REQ-009 SHALL have port cpu_we, input, 1, CPU write request.
REQ-010 SHALL have port cpu_rdata, output, 8, CPU read data.
REQ-011 SHALL have port cpu_wait, output, 1, CPU stall; request not performed this cycle.
REQ-012 SHALL have port mem_addr, output, 16, SRAM address.
REQ-013 SHALL have port mem_wdata, output, 8, SRAM write data.
REQ-014 SHALL have port mem_re, output, 1, SRAM read enable.
REQ-015 SHALL have port mem_we, output, 1, SRAM write enable.
REQ-016 SHALL have port mem_rdata, input, 8, SRAM read data, valid the cycle after mem_re.
REQ-017 SHALL have port dma_busy, output, 1, high while state != IDLE.
REQ-018 SHALL have port dma_done, output, 1, one-cycle pulse after the last DMA write.

Function
REQ-019 States: IDLE, START, READ, WRITE; state register clocked, next-state logic combinational.
REQ-020 IDLE: CPU owns the bus. mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_re = cpu_re, mem_we = cpu_we, cpu_rdata = mem_rdata, cpu_wait = 0.
REQ-021 IDLE, cpu_we with cpu_addr == DMA_REG_ADDR: dma_src_q <= cpu_wdata, idx <= 0, next state START; mem_we = 0 (not forwarded).
REQ-022 IDLE, cpu_re with cpu_addr == DMA_REG_ADDR: mem_re = 0; the cycle after, cpu_rdata = dma_src_q.
REQ-023 START: single idle bus cycle (mem_re = mem_we = 0), then READ.
REQ-024 READ: mem_addr = {src_hi, idx}, mem_re = 1, then WRITE.
REQ-025 WRITE: mem_addr = {OAM_BASE_HI, idx}, mem_wdata = mem_rdata, mem_we = 1; if idx == DMA_LEN-1, next state IDLE and dma_done = 1 in the following cycle; else idx <= idx+1, next state READ.
REQ-026 src_hi = dma_src_q for 8'h00..8'hDF; for 8'hE0..8'hFF, src_hi = dma_src_q - 8'h20 (echo RAM remap).
REQ-027 idx: 8-bit, range 0..DMA_LEN-1, never wraps past DMA_LEN-1.
REQ-028 Busy latency: start write in cycle 0 -> dma_busy high cycles 1..(1 + 2*DMA_LEN), i.e. 321 cycles at default; dma_done at cycle 322.
REQ-029 Any state != IDLE: cpu_wait = cpu_re | cpu_we (combinational); CPU request not forwarded; DMA register writes ignored (no restart).
REQ-030 Simultaneous CPU request and IDLE->START transition: the triggering write completes; a request in the next cycle stalls.
REQ-031 Back-to-back start: a DMA_REG_ADDR write in the cycle dma_done is high is accepted (state IDLE).

Reset
REQ-032 rst high: state = IDLE, idx = 0, dma_src_q = 8'hFF, dma_done = 0, dma_busy = 0, regardless of clk.
REQ-033 rst mid-transfer: abort immediately, no further mem_we; partially written OAM not restored.
REQ-034 Post-reset outputs: mem_re/mem_we follow CPU inputs; cpu_wait = 0.

Structure
REQ-035 dma_state_t enum, DMA_REG_ADDR, OAM_BASE_HI and DMA_LEN defaults SHALL live in the shared constants package.
REQ-036 Single module, no sub-modules; idx counter and state register inline.

Verification
REQ-037 Basic: preload 0xC000..0xC09F with i^8'h5A, write 8'hC0 to FF46 -> FE00..FE9F match, dma_done at cycle 322, dma_busy high 321 cycles.
REQ-038 Stall: CPU read of 0xC000 at cycle 50 of DMA -> cpu_wait = 1, mem_re driven by DMA only; read completes in first IDLE cycle.
REQ-039 Echo: write 8'hE1 to FF46 -> source reads at 0xC100..0xC19F.
REQ-040 Register: write 8'h80 to FF46, read FF46 after completion -> 8'h80, mem_re/mem_we low during the register access cycle.
REQ-041 Reset: assert rst at idx 40 -> dma_busy 0 same cycle, FE28..FE9F unchanged, next FF46 read returns 8'hFF.
REQ-042 Ignored restart: FF46 write during DMA -> cpu_wait = 1, dma_src_q unchanged, transfer still 160 bytes.

Source files
------------

// File: rtl/oam_dma_arbiter_pkg.sv
// Shared constants and types for the OAM DMA arbiter: state encoding,
// default register/page addresses and the echo-RAM source remap.
package oam_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

  localparam int unsigned DMA_LEN_DEF      = 160;
  localparam logic [15:0] DMA_REG_ADDR_DEF = 16'hFF46;
  localparam logic [7:0]  OAM_BASE_HI_DEF  = 8'hFE;
  localparam logic [7:0]  DMA_SRC_RST      = 8'hFF;

  // Pages E0..FF mirror C0..DF, so the DMA never fetches from the echo region.
  function automatic logic [7:0] src_page(input logic [7:0] src);
    return (src >= 8'hE0) ? (src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// Arbitrates one SRAM port between the CPU and an OAM DMA engine that copies
// DMA_LEN bytes from page {src,00} into page {OAM_BASE_HI,00}.
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter int unsigned DMA_LEN      = DMA_LEN_DEF,
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
  parameter logic [7:0]  OAM_BASE_HI  = OAM_BASE_HI_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_re,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_wait,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        dma_busy,
  output logic        dma_done
);

  localparam logic [7:0] IDX_LAST = 8'(DMA_LEN - 1);

  dma_state_t state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] src_q, src_d;
  logic       done_q, done_d;
  logic       reg_rd_q, reg_rd_d;
  logic       reg_hit;

  assign reg_hit = (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 8'h00;
      src_q    <= DMA_SRC_RST;
      done_q   <= 1'b0;
      reg_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      src_q    <= src_d;
      done_q   <= done_d;
      reg_rd_q <= reg_rd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    src_d     = src_q;
    done_d    = 1'b0;
    reg_rd_d  = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_re = cpu_re;
        mem_we = cpu_we;
        // The DMA register lives here, not in SRAM: never forward its accesses.
        if (cpu_we && reg_hit) begin
          mem_re  = 1'b0;
          mem_we  = 1'b0;
          src_d   = cpu_wdata;
          idx_d   = 8'h00;
          state_d = START;
        end else if (cpu_re && reg_hit) begin
          mem_re   = 1'b0;
          reg_rd_d = 1'b1;
        end
      end
      START: state_d = READ;
      READ: begin
        mem_addr = {src_page(src_q), idx_q};
        mem_re   = 1'b1;
        state_d  = WRITE;
      end
      WRITE: begin
        mem_addr  = {OAM_BASE_HI, idx_q};
        mem_wdata = mem_rdata;
        mem_we    = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 8'h01;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dma_busy  = (state_q != IDLE);
  assign cpu_wait  = dma_busy & (cpu_re | cpu_we);
  assign dma_done  = done_q;
  // Register reads return the latched source page one cycle later, like SRAM.
  assign cpu_rdata = reg_rd_q ? src_q : mem_rdata;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Randomized bench for oam_dma_arbiter: SRAM model plus a cycle-position
// reference of the DMA bus schedule derived from the transfer rules.
module tb_oam_dma_arbiter;

  localparam int          LEN      = 160;
  localparam int          BUSY_CYC = 1 + 2 * LEN;
  localparam logic [15:0] REG_A    = 16'hFF46;
  localparam logic [7:0]  OAM_HI   = 8'hFE;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_re, cpu_we;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re, mem_we;
  logic [7:0]  mem_rdata;
  logic        dma_busy, dma_done;

  int          n_chk = 0;
  int          n_fail = 0;
  int          epoch = 100;
  int unsigned salt = 32'h1234_5678;
  bit          pat_mode = 1'b0;
  logic [7:0]  wr_data [65536];
  int          wr_ep   [65536];

  always #5 clk = ~clk;

  oam_dma_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .dma_busy(dma_busy), .dma_done(dma_done)
  );

  // Unwritten locations hold a per-epoch hash; bumping epoch "refills" memory.
  function automatic logic [7:0] minit(input logic [15:0] a);
    logic [31:0] h;
    if (pat_mode && a[15:8] == 8'hC0) return a[7:0] ^ 8'h5A;
    h = ({16'h0, a} ^ salt) * 32'h9E37_79B1;
    return h[23:16];
  endfunction

  function automatic logic [7:0] mrd(input logic [15:0] a);
    return (wr_ep[a] == epoch) ? wr_data[a] : minit(a);
  endfunction

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mrd(mem_addr);
    if (mem_we) begin
      wr_data[mem_addr] <= mem_wdata;
      wr_ep[mem_addr]   <= epoch;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  task automatic drive(input logic re, input logic we, input logic [15:0] a, input logic [7:0] d);
    cpu_re = re; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] page_of(input logic [7:0] src);
    return (src >= 8'hE0) ? src - 8'h20 : src;
  endfunction

  task automatic reg_read(input logic [7:0] expv);
    next_cyc();
    drive(1'b1, 1'b0, REG_A, 8'h00);
    #3;
    chk("regrd_mem_re", mem_re, 0);
    chk("regrd_mem_we", mem_we, 0);
    chk("regrd_wait", cpu_wait, 0);
    next_cyc();
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    #3;
    chk("regrd_data", cpu_rdata, expv);
  endtask

  // Cycle 0 issues the start write; cycle k of the transfer is START for k=1,
  // a read of byte (k-2)/2 for even k and a write of byte (k-3)/2 for odd k>=3.
  task automatic run_dma(input logic [7:0] src, input bit rand_cpu, input int stall_at,
                         input int restart_at, input bit chain, input bit done_in);
    logic [7:0]  hi, stall_exp;
    logic [7:0]  exp_src [LEN];
    logic [15:0] ea;
    logic        er, ew, creq;
    int          last_k;
    next_cyc();
    epoch++;
    salt = $urandom;
    hi = page_of(src);
    for (int i = 0; i < LEN; i++) exp_src[i] = mrd({hi, 8'(i)});
    stall_exp = mrd(16'hC000);
    drive(1'b0, 1'b1, REG_A, src);
    #3;
    chk("c0_done", dma_done, done_in);
    chk("c0_mem_we", mem_we, 0);
    chk("c0_wait", cpu_wait, 0);
    chk("c0_busy", dma_busy, 0);
    last_k = chain ? BUSY_CYC : (stall_at > 0 ? BUSY_CYC + 2 : BUSY_CYC + 1);
    for (int k = 1; k <= last_k; k++) begin
      next_cyc();
      if (stall_at > 0 && k >= stall_at && k <= BUSY_CYC + 1)
        drive(1'b1, 1'b0, 16'hC000, 8'h00);
      else if (k == restart_at)
        drive(1'b0, 1'b1, REG_A, ~src);
      else if (rand_cpu && k <= BUSY_CYC)
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
      else
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
      #3;
      creq = cpu_re | cpu_we;
      if (k <= BUSY_CYC) begin
        er = (k >= 2) && (k % 2 == 0);
        ew = (k >= 3) && (k % 2 == 1);
        ea = er ? {hi, 8'((k - 2) / 2)} : {OAM_HI, 8'((k - 3) / 2)};
        chk($sformatf("busy k%0d", k), dma_busy, 1);
        chk($sformatf("wait k%0d", k), cpu_wait, creq);
        chk($sformatf("mem_re k%0d", k), mem_re, er);
        chk($sformatf("mem_we k%0d", k), mem_we, ew);
        chk($sformatf("done k%0d", k), dma_done, 0);
        if (er || ew) chk($sformatf("mem_addr k%0d", k), mem_addr, ea);
        if (ew) chk($sformatf("mem_wdata k%0d", k), mem_wdata, exp_src[(k - 3) / 2]);
      end else if (k == BUSY_CYC + 1) begin
        chk("end_done", dma_done, 1);
        chk("end_busy", dma_busy, 0);
        chk("end_wait", cpu_wait, 0);
        chk("end_mem_re", mem_re, (stall_at > 0));
        chk("end_mem_we", mem_we, 0);
        if (stall_at > 0) chk("stall_addr", mem_addr, 16'hC000);
      end else begin
        chk("stall_rdata", cpu_rdata, stall_exp);
      end
    end
    if (!chain)
      for (int i = 0; i < LEN; i++)
        chk($sformatf("oam %0d", i), mrd({OAM_HI, 8'(i)}), exp_src[i]);
  endtask

  // Reset lands while byte 40 is being read: bytes 0..39 copied, rest untouched.
  task automatic rst_mid(input logic [7:0] src);
    logic [7:0] hi;
    logic [7:0] exp_src [LEN];
    logic [7:0] oam_old [LEN];
    next_cyc();
    epoch++;
    salt = $urandom;
    hi = page_of(src);
    for (int i = 0; i < LEN; i++) begin
      exp_src[i] = mrd({hi, 8'(i)});
      oam_old[i] = mrd({OAM_HI, 8'(i)});
    end
    drive(1'b0, 1'b1, REG_A, src);
    for (int k = 1; k <= 82; k++) begin
      next_cyc();
      drive(1'b0, 1'b0, 16'h0000, 8'h00);
    end
    #1;
    chk("pre_rst_re", mem_re, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", dma_busy, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_done", dma_done, 0);
    next_cyc();
    chk("rst_hold_we", mem_we, 0);
    next_cyc();
    rst = 1'b0;
    #3;
    chk("post_rst_busy", dma_busy, 0);
    chk("post_rst_we", mem_we, 0);
    for (int i = 0; i < LEN; i++)
      chk($sformatf("rst_oam %0d", i), mrd({OAM_HI, 8'(i)}), (i < 40) ? exp_src[i] : oam_old[i]);
    reg_read(8'hFF);
  endtask

  initial begin
    logic [7:0] s, s2;
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h1234, 8'h00);
    #3;
    chk("reset_busy", dma_busy, 0);
    chk("reset_done", dma_done, 0);
    chk("reset_wait", cpu_wait, 0);
    chk("reset_mem_re", mem_re, 1);
    chk("reset_mem_addr", mem_addr, 16'h1234);
    drive(1'b0, 1'b1, 16'h2345, 8'hA5);
    #1;
    chk("reset_mem_we", mem_we, 1);
    chk("reset_wdata", mem_wdata, 8'hA5);
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    #20;
    next_cyc();
    rst = 1'b0;
    reg_read(8'hFF);

    pat_mode = 1'b1;
    run_dma(8'hC0, 1'b0, 0, 0, 1'b0, 1'b0);
    run_dma(8'hC0, 1'b0, 50, 0, 1'b0, 1'b0);
    pat_mode = 1'b0;
    run_dma(8'hE1, 1'b1, 0, 0, 1'b0, 1'b0);
    run_dma(8'h80, 1'b0, 0, 0, 1'b0, 1'b0);
    reg_read(8'h80);

    s = 8'($urandom_range(0, 255));
    run_dma(s, 1'b0, 0, 100, 1'b0, 1'b0);
    reg_read(s);

    s  = 8'($urandom_range(0, 255));
    s2 = 8'($urandom_range(0, 255));
    run_dma(s, 1'b1, 0, 0, 1'b1, 1'b0);
    run_dma(s2, 1'b1, 0, 0, 1'b0, 1'b1);
    reg_read(s2);

    for (int r = 0; r < 3; r++) begin
      s = 8'($urandom_range(0, 255));
      run_dma(s, 1'b1, 0, 0, 1'b0, 1'b0);
      reg_read(s);
    end

    rst_mid(8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
